// File: rtl/apo_inject_scheduler.sv
// Request-driven injection scheduler for the circulant APO router ring.
// An in-order request FIFO feeds one-cycle in_free pulses, with a per-router cooldown between injections.
module apo_inject_scheduler #(
   parameter int unsigned NODES = 36,
   parameter int unsigned N2    = 13,
   parameter int unsigned DEPTH = 8,
   parameter int unsigned GAP   = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [5:0]          req_node,
   input  logic [N2-1:0]       req_word,
   output logic [NODES*N2-1:0] out_free,
   output logic                inj_valid,
   output logic [5:0]          inj_node,
   output logic                req_err,
   output logic                busy,
   output logic [15:0]         inj_count
);

   localparam int unsigned PW  = $clog2(DEPTH);
   localparam int unsigned CW  = PW + 1;
   localparam int unsigned NW  = 6;
   localparam int unsigned CDW = 4;

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_DISPATCH = 2'd1;
   localparam logic [1:0] ST_STALL    = 2'd2;

   logic [1:0]          state_q, state_d;
   logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]       count_q, count_d;
   logic [NW-1:0]       node_mem_q [DEPTH];
   logic [N2-1:0]       word_mem_q [DEPTH];
   logic [CDW-1:0]      cd_q [NODES];
   logic [CDW-1:0]      cd_d [NODES];
   logic [NODES*N2-1:0] out_free_q, out_free_d;
   logic                inj_valid_q;
   logic [NW-1:0]       inj_node_q;
   logic                req_err_q;
   logic [15:0]         inj_count_q;

   logic          fifo_empty;
   logic          accept, legal, push, pop, last_pop;
   logic [NW-1:0] head_node;
   logic [N2-1:0] head_word;
   logic          head_elig;
   logic          cd_busy;

   assign fifo_empty = (count_q == '0);
   assign req_ready  = (count_q < CW'(DEPTH));
   assign accept     = req_valid & req_ready;
   assign legal      = (req_node < NW'(NODES)) && (req_word != '0);
   assign push       = accept & legal;
   assign head_node  = node_mem_q[rd_ptr_q];
   assign head_word  = word_mem_q[rd_ptr_q];
   assign head_elig  = (cd_q[head_node] == '0);
   assign last_pop   = (count_q == CW'(1)) && !push;

   // Dispatch FSM: strict head-of-line, pop whenever the head router has cooled down
   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      case (state_q)
         ST_IDLE, ST_DISPATCH: begin
            if (fifo_empty) begin
               state_d = ST_IDLE;
            end else if (head_elig) begin
               pop     = 1'b1;
               state_d = last_pop ? ST_IDLE : ST_DISPATCH;
            end else begin
               state_d = ST_STALL;
            end
         end
         ST_STALL: begin
            if (!fifo_empty && head_elig) begin
               pop     = 1'b1;
               state_d = last_pop ? ST_IDLE : ST_DISPATCH;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Cooldown counters and the one-hot-slice output word
   always_comb begin
      out_free_d = '0;
      cd_busy    = 1'b0;
      for (int unsigned k = 0; k < NODES; k++) begin
         cd_busy = cd_busy | (cd_q[k] != '0);
         if (pop && (head_node == NW'(k))) begin
            cd_d[k]                  = CDW'(GAP - 1);
            out_free_d[k*N2 +: N2]   = head_word;
         end else if (cd_q[k] != '0) begin
            cd_d[k] = cd_q[k] - CDW'(1);
         end else begin
            cd_d[k] = cd_q[k];
         end
      end
   end

   assign busy = !fifo_empty || cd_busy;

   always_ff @(posedge clk) begin
      if (push) begin
         node_mem_q[wr_ptr_q] <= req_node;
         word_mem_q[wr_ptr_q] <= req_word;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         out_free_q  <= '0;
         inj_valid_q <= 1'b0;
         inj_node_q  <= '0;
         req_err_q   <= 1'b0;
         inj_count_q <= '0;
         for (int unsigned k = 0; k < NODES; k++) begin
            cd_q[k] <= '0;
         end
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         out_free_q  <= out_free_d;
         inj_valid_q <= pop;
         inj_node_q  <= pop ? head_node : '0;
         req_err_q   <= accept & !legal;
         inj_count_q <= inj_count_q + 16'(pop);
         if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         for (int unsigned k = 0; k < NODES; k++) begin
            cd_q[k] <= cd_d[k];
         end
      end
   end

   assign out_free  = out_free_q;
   assign inj_valid = inj_valid_q;
   assign inj_node  = inj_node_q;
   assign req_err   = req_err_q;
   assign inj_count = inj_count_q;

endmodule

// File: tb/tb_apo_inject_scheduler.sv
// Randomized and directed bench for apo_inject_scheduler against a time-stamp based queue model.
module tb_apo_inject_scheduler;

   localparam int NODES = 36;
   localparam int N2    = 13;
   localparam int DEPTH = 8;
   localparam int GAP   = 4;
   localparam int FW    = NODES * N2;

   typedef struct packed {
      logic [5:0]    node;
      logic [N2-1:0] word;
   } req_t;

   logic          clk;
   logic          rst;
   logic          req_valid;
   logic          req_ready;
   logic [5:0]    req_node;
   logic [N2-1:0] req_word;
   logic [FW-1:0] out_free;
   logic          inj_valid;
   logic [5:0]    inj_node;
   logic          req_err;
   logic          busy;
   logic [15:0]   inj_count;

   apo_inject_scheduler #(.NODES(NODES), .N2(N2), .DEPTH(DEPTH), .GAP(GAP)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_node  (req_node),
      .req_word  (req_word),
      .out_free  (out_free),
      .inj_valid (inj_valid),
      .inj_node  (inj_node),
      .req_err   (req_err),
      .busy      (busy),
      .inj_count (inj_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   edge_n   = 0;
   req_t mq[$];
   int   last_inj [NODES];
   logic [15:0] exp_cnt;
   bit   last_acc;

   task automatic check_eq(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s @edge %0d: got %0h expected %0h", tag, edge_n, obs, exp);
      end
   endtask

   function automatic bit model_busy();
      bit b = (mq.size() != 0);
      for (int k = 0; k < NODES; k++)
         if (edge_n - last_inj[k] < GAP - 1) b = 1'b1;
      return b;
   endfunction

   // One clock of stimulus, model update and output comparison
   task automatic step(input logic v, input logic [5:0] nd, input logic [N2-1:0] wd);
      bit            rdy, legal, pop;
      req_t          ent;
      logic [FW-1:0] exp_free;
      logic [5:0]    exp_node;
      req_valid = v;
      req_node  = nd;
      req_word  = wd;
      rdy = (mq.size() < DEPTH);
      @(posedge clk);
      edge_n++;
      last_acc = v && rdy;
      legal    = (int'(nd) < NODES) && (wd != '0);
      pop      = 1'b0;
      exp_free = '0;
      exp_node = '0;
      if (mq.size() != 0 && (edge_n - last_inj[mq[0].node] >= GAP)) begin
         ent = mq.pop_front();
         pop = 1'b1;
         exp_free[int'(ent.node)*N2 +: N2] = ent.word;
         exp_node = ent.node;
         last_inj[ent.node] = edge_n;
         exp_cnt = exp_cnt + 16'd1;
      end
      if (last_acc && legal) mq.push_back('{node: nd, word: wd});
      #1;
      check_eq("out_free",  out_free,  exp_free);
      check_eq("inj_valid", inj_valid, pop);
      check_eq("inj_node",  inj_node,  exp_node);
      check_eq("req_err",   req_err,   last_acc && !legal);
      check_eq("inj_count", inj_count, exp_cnt);
      check_eq("busy",      busy,      model_busy());
      check_eq("req_ready", req_ready, mq.size() < DEPTH);
   endtask

   task automatic do_reset(input int n);
      rst       = 1'b1;
      req_valid = 1'($urandom);
      req_node  = 6'($urandom);
      req_word  = 13'($urandom);
      repeat (n) @(posedge clk);
      edge_n += n;
      mq.delete();
      for (int k = 0; k < NODES; k++) last_inj[k] = -1000;
      exp_cnt = '0;
      #1;
      check_eq("rst_out_free",  out_free,  '0);
      check_eq("rst_inj_valid", inj_valid, 1'b0);
      check_eq("rst_inj_node",  inj_node,  '0);
      check_eq("rst_req_err",   req_err,   1'b0);
      check_eq("rst_inj_count", inj_count, '0);
      check_eq("rst_busy",      busy,      1'b0);
      check_eq("rst_req_ready", req_ready, 1'b1);
      rst       = 1'b0;
      req_valid = 1'b0;
   endtask

   task automatic send(input logic [5:0] nd, input logic [N2-1:0] wd);
      int tries = 0;
      do begin
         step(1'b1, nd, wd);
         tries++;
      end while (!last_acc && tries < 200);
      check_eq("send_accept", last_acc, 1'b1);
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 6'd0, '0);
   endtask

   initial begin
      bit            have_pend;
      logic [5:0]    p_node;
      logic [N2-1:0] p_word;
      rst = 1'b1; req_valid = 1'b0; req_node = '0; req_word = '0;
      exp_cnt = '0; last_acc = 1'b0;

      do_reset(2);
      idle(2);

      send(6'd5, 13'h0A3);
      idle(4);

      send(6'd3, 13'h111);
      send(6'd3, 13'h222);
      send(6'd7, 13'h333);
      idle(10);

      send(6'd0, 13'h001);
      for (int i = 0; i < 10; i++) send(6'd0, N2'(i + 2));
      idle(45);

      send(6'd36, 13'h055);
      idle(1);
      send(6'd9, 13'h000);
      idle(2);
      send(6'd63, 13'h1FF);
      idle(2);

      send(6'd2, 13'h0F0);
      idle(1);
      for (int i = 0; i < 4; i++) send(6'd2, N2'(i + 1));
      do_reset(1);
      send(6'd2, 13'h0AB);
      idle(4);

      have_pend = 1'b0;
      p_node    = '0;
      p_word    = '0;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 599) == 0) begin
            do_reset(1 + $urandom_range(0, 1));
            have_pend = 1'b0;
         end
         if (!have_pend && $urandom_range(0, 3) != 0) begin
            have_pend = 1'b1;
            case ($urandom_range(0, 9))
               0:       p_node = 6'(36 + $urandom_range(0, 27));
               1, 2:    p_node = 6'($urandom_range(0, NODES - 1));
               default: p_node = 6'($urandom_range(0, 4));
            endcase
            p_word = ($urandom_range(0, 11) == 0) ? '0 : N2'($urandom);
         end
         step(have_pend, p_node, p_word);
         if (last_acc) have_pend = 1'b0;
      end
      idle(20);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
